md_iter_unit: RTL

//  Iterative multi-cycle multiply/divide responder for the CPU datapath. Accepts the
//  MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU encodings (funct + sa selector) from the

---
 rtl/md_pkg.sv | 12 +
 rtl/md_iter_unit_shift_core.sv | 53 +++++
 rtl/md_iter_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and encodings for the iterative multiply/divide unit.
package md_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_MULU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  localparam logic [4:0] SEL_LO = 5'b00010;
  localparam logic [4:0] SEL_HI = 5'b00011;
endpackage

// File: rtl/md_iter_unit_shift_core.sv
// Radix-2 datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
// Multiply: {hi,lo} = product. Divide: hi = remainder, lo = quotient.
module md_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_sr,
  input  logic [WIDTH-1:0] load_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] acc, sr, opnd;
  logic [WIDTH:0]   sum, shifted, diff;

  // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
  always_comb begin
    sum     = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
    shifted = {acc, sr[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sr   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      sr   <= load_sr;
      opnd <= load_op;
    end else if (step) begin
      if (is_div) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          sr  <= {sr[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted[WIDTH-1:0];
          sr  <= {sr[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= sum[WIDTH:1];
        sr  <= {sum[0], sr[WIDTH-1:1]};
      end
    end
  end

  assign hi = acc;
  assign lo = sr;
endmodule

// File: rtl/md_iter_unit.sv
// Iterative MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU unit with start/busy/done handshake.
// Optional MD_EARLY_OUT_EN: zero divisor (or zero multiplicand on multiply) skips CALC.
module md_iter_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [5:0]       funct,
  input  logic [4:0]       sa,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  md_state_t          state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         funct_q;
  logic               sel_hi, a_neg, b_neg, b_zero, skip;
  logic               in_signed, in_div, early_go, accept, fix_go, is_div_q, neg;
  logic [WIDTH-1:0]   a_mag, b_mag, hi, lo, quo, rem_mag, rem, fix_val;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign in_signed = (funct == F_MUL) || (funct == F_DIV);
  assign in_div    = (funct == F_DIV) || (funct == F_DIVU);
  assign a_mag     = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag     = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;

`ifdef MD_EARLY_OUT_EN
  assign early_go = (op_b == '0) || (((funct == F_MUL) || (funct == F_MULU)) && (op_a == '0));
`else
  assign early_go = 1'b0;
`endif

  // cancel wins over start in IDLE
  assign accept   = (state == IDLE) && start && !cancel;
  assign fix_go   = (state == FIX) && !cancel;
  assign is_div_q = (funct_q == F_DIV) || (funct_q == F_DIVU);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = early_go ? FIX : CALC;
      CALC: if (cancel) state_nx = IDLE;
            else if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = cancel ? IDLE : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  md_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step    (state == CALC),
    .is_div  (is_div_q),
    .load_sr (in_div ? a_mag : b_mag),
    .load_op (in_div ? b_mag : a_mag),
    .hi      (hi),
    .lo      (lo)
  );

  // Sign fix-up; a skipped op never ran CALC, so its product is zero and
  // the dividend magnitude still sits in the quotient register.
  always_comb begin
    neg     = a_neg ^ b_neg;
    prod    = skip ? '0 : {hi, lo};
    prod_s  = neg ? -prod : prod;
    rem_mag = skip ? lo : hi;
    rem     = a_neg ? -rem_mag : rem_mag;
    quo     = b_zero ? '1 : (neg ? -lo : lo);
    case (funct_q)
      F_MUL, F_MULU: fix_val = sel_hi ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
      F_DIV, F_DIVU: fix_val = sel_hi ? rem : quo;
      default:       fix_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      funct_q  <= '0;
      sel_hi   <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      skip     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= '0;
        funct_q <= funct;
        sel_hi  <= (sa != SEL_LO);
        a_neg   <= in_signed && op_a[WIDTH-1];
        b_neg   <= in_signed && op_b[WIDTH-1];
        b_zero  <= (op_b == '0);
        skip    <= early_go;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
      if (fix_go) begin
        result   <= fix_val;
        div_zero <= is_div_q && b_zero;
      end
    end
  end
endmodule
